// File: rtl/alu_decode_stage.sv
// Registered RV32I OP / OP-IMM decode stage with valid/ready handshakes,
// a two-entry skid buffer (registered in_ready) and a saturating illegal counter.
module alu_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_control,
  output logic             regwrite_control,
  output logic             alu_src_imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_OR   = 4'b0010,
    ALU_AND  = 4'b0011, ALU_XOR  = 4'b0100, ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110, ALU_SLL  = 4'b0111, ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef struct packed {
    logic [3:0]      alu;
    logic            regwrite;
    logic            src_imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } bundle_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_legal;
  logic       w_is_imm;
  alu_op_e    w_alu;
  logic [XLEN-1:0] w_imm;
  bundle_t    w_dec;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_legal  = 1'b0;
    w_is_imm = 1'b0;
    w_alu    = ALU_ADD;
    w_imm    = '0;
    unique case (w_opcode)
      OPC_OP: begin
        if (w_f7 == F7_BASE) begin
          w_legal = 1'b1;
          unique case (w_f3)
            3'd0: w_alu = ALU_ADD;
            3'd1: w_alu = ALU_SLL;
            3'd2: w_alu = ALU_SLT;
            3'd3: w_alu = ALU_SLTU;
            3'd4: w_alu = ALU_XOR;
            3'd5: w_alu = ALU_SRL;
            3'd6: w_alu = ALU_OR;
            3'd7: w_alu = ALU_AND;
          endcase
        end else if (w_f7 == F7_ALT) begin
          if (w_f3 == 3'd0) begin
            w_legal = 1'b1;
            w_alu   = ALU_SUB;
          end else if (w_f3 == 3'd5) begin
            w_legal = 1'b1;
            w_alu   = ALU_SRA;
          end
        end
      end
      OPC_OP_IMM: begin
        w_is_imm = 1'b1;
        w_imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        unique case (w_f3)
          3'd0: begin w_legal = 1'b1; w_alu = ALU_ADD;  end
          3'd2: begin w_legal = 1'b1; w_alu = ALU_SLT;  end
          3'd3: begin w_legal = 1'b1; w_alu = ALU_SLTU; end
          3'd4: begin w_legal = 1'b1; w_alu = ALU_XOR;  end
          3'd6: begin w_legal = 1'b1; w_alu = ALU_OR;   end
          3'd7: begin w_legal = 1'b1; w_alu = ALU_AND;  end
          3'd1: begin
            w_imm   = {{(XLEN-5){1'b0}}, in_instr[24:20]};
            w_legal = (w_f7 == F7_BASE);
            w_alu   = ALU_SLL;
          end
          3'd5: begin
            w_imm   = {{(XLEN-5){1'b0}}, in_instr[24:20]};
            w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
            w_alu   = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
        endcase
      end
      default: ;
    endcase
  end

  // Illegal encodings keep the raw register fields but zero all control.
  always_comb begin
    w_dec          = '0;
    w_dec.rs1      = in_instr[19:15];
    w_dec.rs2      = in_instr[24:20];
    w_dec.rd       = in_instr[11:7];
    w_dec.illegal  = !w_legal;
    if (w_legal) begin
      w_dec.alu      = w_alu;
      w_dec.src_imm  = w_is_imm;
      w_dec.imm      = w_imm;
      w_dec.regwrite = (in_instr[11:7] != 5'd0);
      if (w_is_imm) w_dec.rs2 = 5'd0;
    end
  end

  bundle_t r_prim, r_skid;
  logic    r_prim_valid, r_skid_valid, r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  bundle_t w_prim_nxt, w_skid_nxt;
  logic    w_prim_valid_nxt, w_skid_valid_nxt;
  logic    w_accept, w_complete;

  assign w_accept   = in_valid && r_in_ready;
  assign w_complete = r_prim_valid && out_ready;

  always_comb begin
    w_prim_nxt       = r_prim;
    w_prim_valid_nxt = r_prim_valid;
    w_skid_nxt       = r_skid;
    w_skid_valid_nxt = r_skid_valid;
    if (!r_prim_valid || w_complete) begin
      if (r_skid_valid) begin
        w_prim_nxt       = r_skid;
        w_prim_valid_nxt = 1'b1;
        w_skid_valid_nxt = w_accept;
        if (w_accept) w_skid_nxt = w_dec;
      end else begin
        w_prim_valid_nxt = w_accept;
        if (w_accept) w_prim_nxt = w_dec;
      end
    end else if (w_accept) begin
      w_skid_nxt       = w_dec;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prim       <= '0;
      r_skid       <= '0;
      r_prim_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_prim       <= w_prim_nxt;
      r_skid       <= w_skid_nxt;
      r_prim_valid <= w_prim_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (w_accept && w_dec.illegal && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready         = r_in_ready;
  assign out_valid        = r_prim_valid;
  assign alu_control      = r_prim.alu;
  assign regwrite_control = r_prim.regwrite;
  assign alu_src_imm      = r_prim.src_imm;
  assign rs1              = r_prim.rs1;
  assign rs2              = r_prim.rs2;
  assign rd               = r_prim.rd;
  assign imm              = r_prim.imm;
  assign illegal          = r_prim.illegal;
  assign illegal_count    = r_cnt;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage: decode vectors, illegal
// counting/saturation, skid-buffer back-pressure and mid-transfer reset.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready, out_valid, regwrite_control, alu_src_imm, illegal;
  logic [3:0]  alu_control;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [15:0] illegal_count;

  logic        s_in_ready, s_out_valid, s_regwrite, s_src_imm, s_illegal;
  logic [3:0]  s_alu;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [31:0] s_imm;
  logic [1:0]  s_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .regwrite_control(regwrite_control),
    .alu_src_imm(alu_src_imm), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  alu_decode_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .out_valid(s_out_valid), .out_ready(out_ready),
    .alu_control(s_alu), .regwrite_control(s_regwrite),
    .alu_src_imm(s_src_imm), .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd), .imm(s_imm),
    .illegal(s_illegal), .illegal_count(s_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_bundle(input string tag, input logic [3:0] e_alu, input logic e_wr,
                              input logic e_src, input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                              input logic [4:0] e_rd, input logic [31:0] e_imm, input logic e_ill);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".alu"},   64'(alu_control), 64'(e_alu));
    check({tag, ".wr"},    64'(regwrite_control), 64'(e_wr));
    check({tag, ".src"},   64'(alu_src_imm), 64'(e_src));
    check({tag, ".rs1"},   64'(rs1), 64'(e_rs1));
    check({tag, ".rs2"},   64'(rs2), 64'(e_rs2));
    check({tag, ".rd"},    64'(rd), 64'(e_rd));
    check({tag, ".imm"},   64'(imm), 64'(e_imm));
    check({tag, ".ill"},   64'(illegal), 64'(e_ill));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3;
    out_ready = 1'b1;

    // Reset held two cycles with in_valid asserted.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.in_ready",  64'(in_ready), 64'd0);
      check("rst.count",     64'(illegal_count), 64'd0);
      check("rst.alu",       64'(alu_control), 64'd0);
      check("rst.rd",        64'(rd), 64'd0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    check("post_rst.in_ready",  64'(in_ready), 64'd1);
    check("post_rst.out_valid", 64'(out_valid), 64'd0);

    // Legal decodes, one at a time, downstream always ready.
    send(32'h002081B3);
    check_bundle("add", 4'b0000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
    send(32'h407302B3);
    check_bundle("sub", 4'b0001, 1'b1, 1'b0, 5'd6, 5'd7, 5'd5, 32'h0, 1'b0);
    send(32'hFFF00093);
    check_bundle("addi", 4'b0000, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b0);
    send(32'h4030D093);
    check_bundle("srai", 4'b1001, 1'b1, 1'b1, 5'd1, 5'd0, 5'd1, 32'h00000003, 1'b0);
    send(32'h8001F113);
    check_bundle("andi", 4'b0011, 1'b1, 1'b1, 5'd3, 5'd0, 5'd2, 32'hFFFFF800, 1'b0);
    send(32'h00208033);
    check_bundle("add_x0", 4'b0000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 1'b0);
    step();
    check("drain.out_valid", 64'(out_valid), 64'd0);

    // Illegal encodings.
    send(32'h00000000);
    check_bundle("ill_zero", 4'b0000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
    check("ill_zero.count", 64'(illegal_count), 64'd1);
    send(32'h022081B3);
    check_bundle("ill_f7", 4'b0000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1);
    check("ill_f7.count", 64'(illegal_count), 64'd2);
    check("sat.count2", 64'(s_count), 64'd2);
    send(32'h40109093);
    check_bundle("ill_slli", 4'b0000, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b1);
    send(32'h00000073);
    check("ill_opc.ill", 64'(illegal), 64'd1);
    send(32'h40209033);
    check("ill_sll_alt.ill", 64'(illegal), 64'd1);
    check("ill.count5", 64'(illegal_count), 64'd5);
    check("sat.count_hold", 64'(s_count), 64'd3);

    // Back-to-back with simultaneous complete: no bubble.
    in_valid = 1'b1; in_instr = 32'h002081B3; step();
    in_instr = 32'h407302B3; step();
    in_valid = 1'b0;
    check_bundle("b2b.second", 4'b0001, 1'b1, 1'b0, 5'd6, 5'd7, 5'd5, 32'h0, 1'b0);
    step();

    // Back-pressure: A -> primary, B -> skid, C waits at the input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3; step();
    check("bp.ready_after_a", 64'(in_ready), 64'd1);
    in_instr  = 32'h407302B3; step();
    check("bp.ready_after_b", 64'(in_ready), 64'd0);
    in_instr  = 32'h4030D093;
    for (int i = 0; i < 3; i++) begin
      check_bundle("bp.stall_a", 4'b0000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
      check("bp.stall_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check_bundle("bp.out_b", 4'b0001, 1'b1, 1'b0, 5'd6, 5'd7, 5'd5, 32'h0, 1'b0);
    check("bp.ready_rise", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check_bundle("bp.out_c", 4'b1001, 1'b1, 1'b1, 5'd1, 5'd0, 5'd1, 32'h3, 1'b0);
    step();
    check("bp.empty", 64'(out_valid), 64'd0);

    // Reset with both entries full discards them.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3; step();
    in_instr  = 32'h407302B3; step();
    in_valid  = 1'b0;
    check("mid.ready_full", 64'(in_ready), 64'd0);
    reset = 1'b1; step();
    check("mid.out_valid", 64'(out_valid), 64'd0);
    check("mid.count", 64'(illegal_count), 64'd0);
    reset = 1'b0; out_ready = 1'b1; step();
    check("mid.in_ready", 64'(in_ready), 64'd1);
    check("mid.no_ghost", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
